msg_framer: RTL

MSG_FRAMER -- requirements
Module: msg_framer

---
 rtl/msg_framer_pkg.sv | 26 ++
 rtl/sat_counter16.sv | 24 ++
 rtl/msg_framer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/msg_framer_pkg.sv
// Shared definitions for the message framer and the downstream parser:
// message-type encodings, default start-of-frame marker, framer states.
package msg_framer_pkg;

  typedef enum logic [1:0] {
    MSG_ADD    = 2'b00,
    MSG_CANCEL = 2'b01,
    MSG_EXEC   = 2'b10,
    MSG_RSVD   = 2'b11
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'b00,
    ST_TYPE    = 2'b01,
    ST_PAYLOAD = 2'b10,
    ST_CHECK   = 2'b11
  } framer_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // A TYPE byte is legal only with clear upper bits and a non-reserved code.
  function automatic logic type_legal(input logic [7:0] type_byte);
    return (type_byte[7:2] == 6'd0) && (type_byte[1:0] != MSG_RSVD);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that increments on enable and sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_r;

  // Saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (inc && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/msg_framer.sv
// Byte-stream framer: SOF, TYPE, PAYLOAD_LEN payload bytes, XOR checksum.
// Emits a one-cycle msg_valid per good frame and keeps saturating statistics.
module msg_framer
  import msg_framer_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 4,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         GAP_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [1:0]               msg_type,
  output logic                     msg_valid,
  output logic [PAYLOAD_LEN*8-1:0] msg_payload,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              chk_err_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int          PW       = PAYLOAD_LEN * 8;
  localparam logic [2:0]  IDX_LAST = 3'(PAYLOAD_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

  framer_state_e  state_r;
  logic [7:0]     type_r;
  logic [PW-1:0]  payload_r;
  logic [7:0]     xor_r;
  logic [2:0]     idx_r;
  logic [15:0]    gap_r;
  logic           msg_valid_r;
  logic [1:0]     msg_type_r;
  logic [PW-1:0]  msg_payload_r;

  logic in_frame_s, timeout_s, chk_byte_s, chk_ok_s, good_s, chk_err_s, drop_s;

  // Timeout fires on the idle cycle that brings the gap count to GAP_TIMEOUT.
  assign in_frame_s = (state_r != ST_HUNT);
  assign timeout_s  = in_frame_s && !rx_valid && (gap_r == GAP_LAST);
  assign chk_byte_s = (state_r == ST_CHECK) && rx_valid;
  assign chk_ok_s   = (rx_byte == xor_r);
  assign good_s     = chk_byte_s && chk_ok_s && type_legal(type_r);
  assign chk_err_s  = chk_byte_s && !chk_ok_s;
  assign drop_s     = (chk_byte_s && chk_ok_s && !type_legal(type_r)) || timeout_s;

  // Frame FSM, gap timer, running XOR and registered message outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_HUNT;
      type_r        <= 8'd0;
      payload_r     <= '0;
      xor_r         <= 8'd0;
      idx_r         <= 3'd0;
      gap_r         <= 16'd0;
      msg_valid_r   <= 1'b0;
      msg_type_r    <= 2'd0;
      msg_payload_r <= '0;
    end else begin
      msg_valid_r <= good_s;
      if (good_s) begin
        msg_type_r    <= type_r[1:0];
        msg_payload_r <= payload_r;
      end

      if (rx_valid || !in_frame_s || timeout_s) begin
        gap_r <= 16'd0;
      end else begin
        gap_r <= gap_r + 16'd1;
      end

      case (state_r)
        ST_HUNT: begin
          if (rx_valid && (rx_byte == SOF_BYTE)) begin
            state_r <= ST_TYPE;
            xor_r   <= 8'd0;
            idx_r   <= 3'd0;
          end
        end
        ST_TYPE: begin
          if (timeout_s) begin
            state_r <= ST_HUNT;
          end else if (rx_valid) begin
            type_r  <= rx_byte;
            xor_r   <= rx_byte;
            idx_r   <= 3'd0;
            state_r <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (timeout_s) begin
            state_r <= ST_HUNT;
          end else if (rx_valid) begin
            payload_r <= {payload_r[PW-9:0], rx_byte};
            xor_r     <= xor_r ^ rx_byte;
            if (idx_r == IDX_LAST) begin
              state_r <= ST_CHECK;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_CHECK: begin
          if (timeout_s || rx_valid) begin
            state_r <= ST_HUNT;
          end
        end
        default: begin
          state_r <= ST_HUNT;
        end
      endcase
    end
  end

  sat_counter16 u_frame_cnt (.clk(clk), .rst_n(rst_n), .inc(good_s),    .count(frame_cnt));
  sat_counter16 u_chk_cnt   (.clk(clk), .rst_n(rst_n), .inc(chk_err_s), .count(chk_err_cnt));
  sat_counter16 u_drop_cnt  (.clk(clk), .rst_n(rst_n), .inc(drop_s),    .count(drop_cnt));

  assign msg_valid   = msg_valid_r;
  assign msg_type    = msg_type_r;
  assign msg_payload = msg_payload_r;

endmodule
